// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, pin count and source-select encoding for pwm_scheduler
package pwm_pkg;
  localparam int CNT_W = 8;
  localparam int DIV_W = 4;
  localparam int PINS = 8;
  typedef enum logic [1:0] {SRC_G0C0, SRC_G0C1, SRC_G1C0, SRC_G1C1} src_e;
  function automatic src_e pin_src(input logic [2*PINS-1:0] sel, input int pin);
    return src_e'(sel[2*pin +: 2]);
  endfunction
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: prescaled period counter with wrap-time shadowed config and two duty comparators
module pwm_gen #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] duty0,
  input  logic [CNT_W-1:0] duty1,
  output logic [1:0]       ch,
  output logic             period_start,
  output logic             cfg_pending
);
  import pwm_pkg::*;
  localparam int PRE_W = (1 << DIV_W) - 1;
  logic [PRE_W-1:0] pre_q, pre_d, mask;
  logic [CNT_W-1:0] cnt_q, cnt_d, duty0_q, duty0_d, duty1_q, duty1_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ps_q, ps_d, tick, wrap;
  always_comb begin
    mask = ~({PRE_W{1'b1}} << div_q);
    tick = pre_q == mask;
    wrap = tick && cnt_q == '1;
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d = tick ? cnt_q + CNT_W'(1) : cnt_q;
    div_d = wrap ? div : div_q;
    duty0_d = wrap ? duty0 : duty0_q;
    duty1_d = wrap ? duty1 : duty1_q;
    ps_d = wrap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      div_q <= '0;
      duty0_q <= '0;
      duty1_q <= '0;
      ps_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      duty0_q <= duty0_d;
      duty1_q <= duty1_d;
      ps_q <= ps_d;
    end
  end
  // full-scale duty must stay high on the last count too
  assign ch[0] = duty0_q == '1 || cnt_q < duty0_q;
  assign ch[1] = duty1_q == '1 || cnt_q < duty1_q;
  assign period_start = ps_q;
  assign cfg_pending = {div, duty0, duty1} != {div_q, duty0_q, duty1_q};
endmodule

// File: rtl/pwm_scheduler.sv
// pwm_scheduler: two shadowed PWM generators routed to eight registered output pins
module pwm_scheduler #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [pwm_pkg::PINS-1:0]   reg_en_out,
  input  logic [pwm_pkg::PINS-1:0]   reg_en_pwm_out,
  input  logic [7:0]                 reg_out_3_0_pwm_gen_channel,
  input  logic [7:0]                 reg_out_7_4_pwm_gen_channel,
  input  logic [CNT_W-1:0]           reg_pwm_gen_0_ch_0_duty_cycle,
  input  logic [CNT_W-1:0]           reg_pwm_gen_0_ch_1_duty_cycle,
  input  logic [CNT_W-1:0]           reg_pwm_gen_1_ch_0_duty_cycle,
  input  logic [CNT_W-1:0]           reg_pwm_gen_1_ch_1_duty_cycle,
  input  logic [2*DIV_W-1:0]         reg_pwm_gen_1_0_frequency_divider,
  output logic [pwm_pkg::PINS-1:0]   pwm_out,
  output logic [1:0]                 period_start,
  output logic [1:0]                 cfg_pending
);
  import pwm_pkg::*;
  logic [3:0]      ch;
  logic [15:0]     sel;
  logic [PINS-1:0] pwm_out_q, pwm_out_d;
  pwm_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_gen0 (
    .clk(clk),
    .rst_n(rst_n),
    .div(reg_pwm_gen_1_0_frequency_divider[DIV_W-1:0]),
    .duty0(reg_pwm_gen_0_ch_0_duty_cycle),
    .duty1(reg_pwm_gen_0_ch_1_duty_cycle),
    .ch(ch[1:0]),
    .period_start(period_start[0]),
    .cfg_pending(cfg_pending[0])
  );
  pwm_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_gen1 (
    .clk(clk),
    .rst_n(rst_n),
    .div(reg_pwm_gen_1_0_frequency_divider[2*DIV_W-1:DIV_W]),
    .duty0(reg_pwm_gen_1_ch_0_duty_cycle),
    .duty1(reg_pwm_gen_1_ch_1_duty_cycle),
    .ch(ch[3:2]),
    .period_start(period_start[1]),
    .cfg_pending(cfg_pending[1])
  );
  assign sel = {reg_out_7_4_pwm_gen_channel, reg_out_3_0_pwm_gen_channel};
  always_comb begin
    pwm_out_d = '0;
    for (int i = 0; i < PINS; i++)
      pwm_out_d[i] = !reg_en_out[i] ? 1'b0 : !reg_en_pwm_out[i] ? 1'b1 : ch[pin_src(sel, i)];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_out_q <= '0;
    else pwm_out_q <= pwm_out_d;
  end
  assign pwm_out = pwm_out_q;
endmodule
